// File: rtl/sha3_absorb_packer_pkg.sv
// Shared definitions for the SHA-3 absorb-side packer.
//   keccak_state_t : 1600-bit state image, [x][y][bit], lane index = x + 5*y
//   packer_state_t : packer FSM states
//   rate_bytes()   : rate R in bytes for the 2-bit mode (224/256/384/512)
//   PAD_DOMAIN     : first padding byte (SHA-3 domain bits plus the first pad 1)
//   PAD_END        : last padding byte (closing pad 1 in the final rate byte)
package sha3_pkg;

  typedef logic [4:0][4:0][63:0] keccak_state_t;

  typedef enum logic [1:0] {IDLE, FILL, PAD, HOLD} packer_state_t;

  localparam logic [7:0] PAD_DOMAIN  = 8'h06;
  localparam logic [7:0] PAD_END     = 8'h80;
  localparam int         STATE_BYTES = 200;

  function automatic logic [7:0] rate_bytes(input logic [1:0] mode);
    case (mode)
      2'd0:    return 8'd144;
      2'd1:    return 8'd136;
      2'd2:    return 8'd104;
      default: return 8'd72;
    endcase
  endfunction

endpackage

// File: rtl/sha3_byte_insert.sv
// Combinational byte insert into a Keccak state image.
// The word carries its first byte in the MSBs; kept bytes (contiguous from
// the MSB) are XORed into message bytes byte_ptr, byte_ptr+1, ...
// Byte k lands in lane k/8, bits [8*(k%8)+7 : 8*(k%8)]. Writing into a
// cleared block and XORing are the same, so one XOR path serves both the
// data beats and the padding bytes. Bytes beyond the 200-byte state drop.
//   state_in  : in  keccak_state_t  current state image
//   byte_ptr  : in  8               message byte index of the first kept byte
//   word      : in  DATA_WIDTH      bytes to insert, first byte in MSBs
//   keep      : in  DATA_WIDTH/8    byte enables, MSB = first byte
//   state_out : out keccak_state_t  updated state image
module sha3_byte_insert
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  keccak_state_t           state_in,
  input  logic [7:0]              byte_ptr,
  input  logic [DATA_WIDTH-1:0]   word,
  input  logic [DATA_WIDTH/8-1:0] keep,
  output keccak_state_t           state_out
);

  localparam int NB = DATA_WIDTH / 8;

  logic [8:0] k;
  logic [5:0] lane;
  logic [2:0] lx;
  logic [2:0] ly;

  always_comb begin
    state_out = state_in;
    k    = '0;
    lane = '0;
    lx   = '0;
    ly   = '0;
    for (int j = 0; j < NB; j++) begin
      if (keep[NB-1-j]) begin
        k = {1'b0, byte_ptr} + 9'(j);
        if (k < 9'(STATE_BYTES)) begin
          lane = k[8:3];
          lx   = 3'(lane % 6'd5);
          ly   = 3'(lane / 6'd5);
          state_out[lx][ly][{k[2:0], 3'b000} +: 8] ^= word[DATA_WIDTH-8-8*j +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/sha3_absorb_packer.sv
// SHA-3 absorb packer: takes the message as an AXI-Stream, packs rate-sized
// blocks into a Keccak state image, appends SHA-3 padding and offers each
// block to the permutation core with a valid/ready handshake.
//   ACLK, ARESET        : clock, async active-high reset
//   S_TDATA/TKEEP/TUSER : message word (first byte in MSBs), byte enables, mode
//   S_TLAST/TVALID      : last beat of message, word valid
//   S_TREADY            : packer accepts word (registered)
//   Block               : state image, Block[x][y] = lane x+5y
//   Block_Mode          : mode latched on the first beat of the message
//   Block_Last          : Block is the final padded block
//   Block_Valid         : Block offered to the core (registered)
//   Block_Ready         : core takes Block
//
// state | meaning
// IDLE  | waiting for first beat of a message; mode latched on it
// FILL  | accepting beats into the current block
// PAD   | one cycle: padding bytes XORed into the block, no input taken
// HOLD  | block offered to the core, held until Block_Ready
module sha3_absorb_packer
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [DATA_WIDTH-1:0]   S_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
  input  logic [1:0]              S_TUSER,
  input  logic                    S_TLAST,
  input  logic                    S_TVALID,
  output logic                    S_TREADY,
  output keccak_state_t           Block,
  output logic [1:0]              Block_Mode,
  output logic                    Block_Last,
  output logic                    Block_Valid,
  input  logic                    Block_Ready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [NB-1:0] KEEP_FIRST = NB'(1) << (NB - 1);

  packer_state_t state_q, state_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          pad_pend_q, pad_pend_d;
  keccak_state_t block_d;
  logic [1:0]    mode_d;
  logic          last_d;

  logic [7:0]            rate;
  logic [7:0]            beat_bytes;
  logic [8:0]            ptr_next;
  logic                  hs;
  keccak_state_t         ins_base, ins_mid, ins_out;
  logic [7:0]            ins_ptr;
  logic [DATA_WIDTH-1:0] ins_word;
  logic [NB-1:0]         ins_keep, end_keep;

  assign hs   = S_TVALID && S_TREADY;
  assign rate = rate_bytes((state_q == IDLE) ? S_TUSER : Block_Mode);

  always_comb begin
    beat_bytes = '0;
    for (int j = 0; j < NB; j++) begin
      if (S_TKEEP[j]) beat_bytes = beat_bytes + 8'd1;
    end
  end

  assign ptr_next = {1'b0, ptr_q} + {1'b0, beat_bytes};

  // Data beats and the PAD_DOMAIN byte share the first insert; the second
  // only acts in PAD and drops PAD_END into byte R-1.
  always_comb begin
    ins_base = Block;
    ins_ptr  = ptr_q;
    ins_word = S_TDATA;
    ins_keep = S_TKEEP;
    end_keep = '0;
    if (state_q == IDLE) begin
      ins_base = '0;
      ins_ptr  = '0;
    end else if (state_q == PAD) begin
      ins_word = DATA_WIDTH'(PAD_DOMAIN) << (DATA_WIDTH - 8);
      ins_keep = KEEP_FIRST;
      end_keep = KEEP_FIRST;
      if (ptr_q >= rate) begin
        ins_base = '0;
        ins_ptr  = '0;
      end
    end
  end

  sha3_byte_insert #(.DATA_WIDTH(DATA_WIDTH)) u_insert_data (
    .state_in  (ins_base),
    .byte_ptr  (ins_ptr),
    .word      (ins_word),
    .keep      (ins_keep),
    .state_out (ins_mid)
  );

  sha3_byte_insert #(.DATA_WIDTH(DATA_WIDTH)) u_insert_end (
    .state_in  (ins_mid),
    .byte_ptr  (rate - 8'd1),
    .word      (DATA_WIDTH'(PAD_END) << (DATA_WIDTH - 8)),
    .keep      (end_keep),
    .state_out (ins_out)
  );

  // A TLAST beat that exactly fills the block must first hand the data
  // block over; pad_pend then routes HOLD into PAD for the all-pad block.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    pad_pend_d = pad_pend_q;
    block_d    = Block;
    mode_d     = Block_Mode;
    last_d     = Block_Last;
    case (state_q)
      IDLE, FILL: begin
        if (hs) begin
          if (state_q == IDLE) mode_d = S_TUSER;
          block_d = ins_out;
          ptr_d   = ptr_next[7:0];
          if (ptr_next >= {1'b0, rate}) begin
            state_d    = HOLD;
            last_d     = 1'b0;
            pad_pend_d = S_TLAST;
          end else if (S_TLAST) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      PAD: begin
        block_d    = ins_out;
        last_d     = 1'b1;
        pad_pend_d = 1'b0;
        state_d    = HOLD;
      end
      HOLD: begin
        if (Block_Ready) begin
          ptr_d   = '0;
          block_d = '0;
          if (Block_Last) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end else if (pad_pend_q) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      pad_pend_q  <= 1'b0;
      Block       <= '0;
      Block_Mode  <= '0;
      Block_Last  <= 1'b0;
      Block_Valid <= 1'b0;
      S_TREADY    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pad_pend_q  <= pad_pend_d;
      Block       <= block_d;
      Block_Mode  <= mode_d;
      Block_Last  <= last_d;
      Block_Valid <= (state_d == HOLD);
      S_TREADY    <= (state_d == IDLE) || (state_d == FILL);
    end
  end

endmodule

// File: tb/tb_sha3_absorb_packer.sv
module tb_sha3_absorb_packer;

  typedef logic [4:0][4:0][63:0] blk_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] S_TDATA;
  logic [1:0]  S_TKEEP;
  logic [1:0]  S_TUSER;
  logic        S_TLAST;
  logic        S_TVALID;
  logic        S_TREADY;
  blk_t        Block;
  logic [1:0]  Block_Mode;
  logic        Block_Last;
  logic        Block_Valid;
  logic        Block_Ready;

  int checks = 0;
  int errors = 0;

  sha3_absorb_packer #(.DATA_WIDTH(16)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .S_TDATA     (S_TDATA),
    .S_TKEEP     (S_TKEEP),
    .S_TUSER     (S_TUSER),
    .S_TLAST     (S_TLAST),
    .S_TVALID    (S_TVALID),
    .S_TREADY    (S_TREADY),
    .Block       (Block),
    .Block_Mode  (Block_Mode),
    .Block_Last  (Block_Last),
    .Block_Valid (Block_Valid),
    .Block_Ready (Block_Ready)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_block(input string tag, input blk_t exp);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        chk($sformatf("%s_lane%0d", tag, x + 5 * y), Block[x][y], exp[x][y]);
  endtask

  function automatic logic [7:0] bval(input int base, input int k);
    return 8'((base + k) & 255);
  endfunction

  function automatic logic [7:0] get_byte(input blk_t b, input int k);
    int lane;
    lane = k / 8;
    return b[lane % 5][lane / 5][8 * (k % 8) +: 8];
  endfunction

  function automatic blk_t put_byte(input blk_t b, input int k, input logic [7:0] v);
    blk_t r;
    int lane;
    r = b;
    lane = k / 8;
    r[lane % 5][lane / 5][8 * (k % 8) +: 8] = v;
    return r;
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
    int n;
    n = 0;
    S_TDATA  = d;
    S_TKEEP  = k;
    S_TLAST  = l;
    S_TVALID = 1'b1;
    while (!S_TREADY && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL s_tready_wait observed %0d cycles required <200", n);
    end
    @(posedge ACLK); #1;
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
  endtask

  task automatic send_bytes(input int base, input int first, input int count, input logic last);
    for (int k = first; k < first + count; k += 2) begin
      int rem;
      rem = first + count - k;
      if (rem >= 2) send_beat({bval(base, k), bval(base, k + 1)}, 2'b11, last && (rem == 2));
      else          send_beat({bval(base, k), 8'h00}, 2'b10, last);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!Block_Valid && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errors++;
      $error("FAIL %s observed %0d cycles without Block_Valid required <50", tag, n);
    end
  endtask

  task automatic take_block();
    Block_Ready = 1'b1;
    @(posedge ACLK); #1;
    Block_Ready = 1'b0;
  endtask

  task automatic run_abc(input string tag, input blk_t exp);
    S_TUSER = 2'd1;
    send_beat(16'h6162, 2'b11, 1'b0);
    S_TUSER = 2'd3;
    send_beat(16'h6300, 2'b10, 1'b1);
    chk({tag, "_valid_pad_cycle"}, 64'(Block_Valid), 64'd0);
    @(posedge ACLK); #1;
    chk({tag, "_valid"}, 64'(Block_Valid), 64'd1);
    chk({tag, "_last"}, 64'(Block_Last), 64'd1);
    chk({tag, "_mode"}, 64'(Block_Mode), 64'd1);
    chk({tag, "_lane0_hand"}, Block[0][0], 64'h0000_0000_0663_6261);
    chk({tag, "_lane16_hand"}, Block[1][3], 64'h8000_0000_0000_0000);
    check_block(tag, exp);
    take_block();
    chk({tag, "_valid_drop"}, 64'(Block_Valid), 64'd0);
    chk({tag, "_tready_idle"}, 64'(S_TREADY), 64'd1);
    S_TUSER = 2'd0;
  endtask

  blk_t exp_abc, exp_a, exp_b, exp_e;

  initial begin
    ARESET      = 1'b1;
    S_TDATA     = '0;
    S_TKEEP     = '0;
    S_TUSER     = '0;
    S_TLAST     = 1'b0;
    S_TVALID    = 1'b0;
    Block_Ready = 1'b0;

    exp_abc = '0;
    exp_abc[0][0] = 64'h0000_0000_0663_6261;
    exp_abc[1][3] = 64'h8000_0000_0000_0000;

    exp_a = '0;
    for (int k = 0; k < 72; k++) exp_a = put_byte(exp_a, k, bval(1, k));
    exp_b = '0;
    exp_b[0][0] = 64'h0000_0000_0000_0006;
    exp_b[3][1] = 64'h8000_0000_0000_0000;
    exp_e = '0;
    exp_e[0][0] = 64'h0000_0000_0000_0006;
    exp_e[2][2] = 64'h8000_0000_0000_0000;

    // reset values
    repeat (2) begin @(posedge ACLK); #1; end
    chk("rst_tready", 64'(S_TREADY), 64'd0);
    chk("rst_valid", 64'(Block_Valid), 64'd0);
    chk("rst_last", 64'(Block_Last), 64'd0);
    chk("rst_mode", 64'(Block_Mode), 64'd0);
    check_block("rst", '0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("idle_tready", 64'(S_TREADY), 64'd1);

    // "abc", mode 1 (mode change on 2nd beat must be ignored)
    run_abc("abc", exp_abc);

    // mode 3, exactly 72 bytes: data block then all-pad block
    S_TUSER = 2'd3;
    send_bytes(1, 0, 72, 1'b1);
    chk("b72_valid_fill", 64'(Block_Valid), 64'd1);
    chk("b72_last0", 64'(Block_Last), 64'd0);
    chk("b72_lane0_hand", Block[0][0], 64'h0807_0605_0403_0201);
    chk("b72_lane8_hand", Block[3][1], 64'h4847_4645_4443_4241);
    check_block("b72_data", exp_a);
    take_block();
    chk("b72_valid_drop", 64'(Block_Valid), 64'd0);
    wait_valid("b72_pad_wait");
    chk("b72_last1", 64'(Block_Last), 64'd1);
    chk("b72_mode", 64'(Block_Mode), 64'd3);
    check_block("b72_pad", exp_b);
    take_block();

    // mode 3, 74 bytes: core stalls 10 cycles with a beat waiting
    S_TUSER = 2'd3;
    send_bytes(1, 0, 72, 1'b0);
    chk("hold_valid", 64'(Block_Valid), 64'd1);
    S_TDATA  = 16'h494A;
    S_TKEEP  = 2'b11;
    S_TLAST  = 1'b1;
    S_TVALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge ACLK); #1;
      chk($sformatf("hold%0d_tready", c), 64'(S_TREADY), 64'd0);
      chk($sformatf("hold%0d_valid", c), 64'(Block_Valid), 64'd1);
      chk($sformatf("hold%0d_lane0", c), Block[0][0], 64'h0807_0605_0403_0201);
      chk($sformatf("hold%0d_lane8", c), Block[3][1], 64'h4847_4645_4443_4241);
    end
    take_block();
    chk("resume_tready", 64'(S_TREADY), 64'd1);
    chk("resume_valid", 64'(Block_Valid), 64'd0);
    send_beat(16'h494A, 2'b11, 1'b1);
    @(posedge ACLK); #1;
    chk("b74_valid", 64'(Block_Valid), 64'd1);
    chk("b74_last", 64'(Block_Last), 64'd1);
    chk("b74_lane0", Block[0][0], 64'h0000_0000_0006_4A49);
    chk("b74_lane8", Block[3][1], 64'h8000_0000_0000_0000);
    chk("b74_lane1", Block[1][0], 64'h0);
    take_block();

    // mode 0, 143 bytes: pad bytes collide at R-1 -> 0x86
    S_TUSER = 2'd0;
    send_bytes(16, 0, 143, 1'b1);
    chk("b143_valid_pad_cycle", 64'(Block_Valid), 64'd0);
    @(posedge ACLK); #1;
    chk("b143_valid", 64'(Block_Valid), 64'd1);
    chk("b143_last", 64'(Block_Last), 64'd1);
    chk("b143_mode", 64'(Block_Mode), 64'd0);
    chk("b143_byte0", 64'(get_byte(Block, 0)), 64'h10);
    chk("b143_byte141", 64'(get_byte(Block, 141)), 64'h9D);
    chk("b143_byte142", 64'(get_byte(Block, 142)), 64'h9E);
    chk("b143_byte143", 64'(get_byte(Block, 143)), 64'h86);
    chk("b143_lane17", Block[2][3], 64'h869E_9D9C_9B9A_9998);
    chk("b143_lane18", Block[3][3], 64'h0);
    take_block();

    // empty message, mode 2
    S_TUSER = 2'd2;
    send_beat(16'h0000, 2'b00, 1'b1);
    wait_valid("empty_wait");
    chk("empty_last", 64'(Block_Last), 64'd1);
    chk("empty_mode", 64'(Block_Mode), 64'd2);
    check_block("empty", exp_e);
    take_block();

    // reset mid-message, then "abc" again
    S_TUSER = 2'd1;
    send_bytes(48, 0, 40, 1'b0);
    ARESET = 1'b1;
    #1;
    chk("abort_valid", 64'(Block_Valid), 64'd0);
    chk("abort_tready", 64'(S_TREADY), 64'd0);
    chk("abort_lane0", Block[0][0], 64'h0);
    chk("abort_lane4", Block[4][0], 64'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (3) begin @(posedge ACLK); #1; end
    chk("abort_no_block", 64'(Block_Valid), 64'd0);
    chk("abort_tready_idle", 64'(S_TREADY), 64'd1);
    run_abc("abc_after_abort", exp_abc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
